uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 100_000_000, inter-byte timeout in clk cycles (1 s at 100 MHz).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_rx_data  input  8  received byte from UART receiver; valid only when i_rx_done=1.
REQ-005 i_rx_done  input  1  single-cycle strobe marking a new received byte.
REQ-006 o_run_stop  output  1  one-cycle pulse: toggle upcounter run/stop.
REQ-007 o_clear  output  1  one-cycle pulse: clear upcounter to 0.
REQ-008 o_load  output  1  one-cycle pulse: load o_load_value into upcounter.
REQ-009 o_load_value  output  14  binary value 0..9999; held stable between loads.
REQ-010 o_err  output  1  one-cycle pulse on malformed or timed-out sequence.

Function
REQ-011 Byte handling SHALL occur only in cycles with i_rx_done=1; every output pulse SHALL assert exactly one cycle after that cycle (registered, latency 1).
REQ-012 FSM states SHALL be IDLE, DIGITS, WAIT_CR.
REQ-013 IDLE: 'R' (0x52) -> o_run_stop pulse; 'C' (0x43) -> o_clear pulse; 'S' (0x53) -> clear accumulator and digit count, go DIGITS; CR/LF and all other bytes ignored, no o_err.
REQ-014 DIGITS: '0'..'9' -> acc = acc*10 + digit, count+1; the 4th digit SHALL move to WAIT_CR.
REQ-015 DIGITS: CR (0x0D) or LF (0x0A) with count 1..3 -> o_load pulse, o_load_value=acc, go IDLE.
REQ-016 DIGITS: CR/LF with count 0, or any non-digit -> o_err pulse, go IDLE, o_load_value unchanged.
REQ-017 WAIT_CR: CR/LF -> o_load pulse, o_load_value=acc, go IDLE; any other byte -> o_err pulse, go IDLE.
REQ-018 Accumulator SHALL be 14 bits unsigned; max 4 digits guarantees no overflow (9999 < 16384).
REQ-019 o_load_value SHALL update in the same cycle o_load asserts.
REQ-020 Timeout counter SHALL run only in DIGITS/WAIT_CR, clear on every i_rx_done and on entry to IDLE; reaching TIMEOUT_CYCLES-1 SHALL pulse o_err and return to IDLE.
REQ-021 Byte arrival and timeout expiry in the same cycle: the byte SHALL win; no o_err from timeout.
REQ-022 Strobes on consecutive cycles SHALL each be processed; no byte dropped.
REQ-023 At most one of o_run_stop, o_clear, o_load, o_err SHALL be high in any cycle.

Reset
REQ-024 reset SHALL force IDLE, accumulator 0, count 0, timer 0, all pulse outputs 0, o_load_value 0, asynchronously.
REQ-025 reset mid-sequence SHALL discard partial digits without o_err or o_load.

Configuration
REQ-026 With CMD_LOWERCASE_EN defined, 'r','c','s' (0x72,0x63,0x73) SHALL act identically to 'R','C','S'.
REQ-027 Without CMD_LOWERCASE_EN, lowercase bytes SHALL be ignored in IDLE and SHALL cause o_err in DIGITS/WAIT_CR.

Structure
REQ-028 ASCII constants (R, C, S, CR, LF, '0', '9') and the FSM state encoding SHALL live in shared package uart_cmd_pkg.
REQ-029 Timeout counter SHALL be sub-module cmd_timeout_timer (inputs clear, enable; output expire pulse).

Verification
REQ-030 'R' strobe at cycle N -> o_run_stop=1 at N+1 only; other outputs 0.
REQ-031 'S','1','2','3','4',CR -> o_load pulse, o_load_value=1234 (14'h04D2).
REQ-032 'S','7',LF -> o_load pulse, o_load_value=7; then 'S',CR -> o_err pulse, o_load_value stays 7.
REQ-033 'S','1','2', then no bytes for TIMEOUT_CYCLES (bench override 1000) -> single o_err pulse, FSM IDLE; next 'C' -> o_clear.
REQ-034 'S','9','9','9','9','5' -> o_err; reset asserted after 'S','4' -> no pulses; then 'R' -> o_run_stop.
REQ-035 'r' with and without CMD_LOWERCASE_EN -> o_run_stop pulse vs no output.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg -- shared constants for the UART command decoder.
//   ASCII command/digit/terminator codes and the decoder FSM state encoding.
//   Optional build macro used by the decoder: CMD_LOWERCASE_EN.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_LR = 8'h72;
    localparam logic [7:0] ASCII_LC = 8'h63;
    localparam logic [7:0] ASCII_LS = 8'h73;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIGITS = 2'd1;
    localparam logic [1:0] ST_WAITCR = 2'd2;

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer -- inter-byte timeout counter.
//   clk, reset : clock / async active-high reset
//   clear_i    : zero the counter (has priority, suppresses expiry)
//   enable_i   : count while high
//   expire_o   : combinational pulse in the cycle the count sits at TIMEOUT_CYCLES-1
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i || expire_o) cnt_d = '0;
        else                                  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder -- decodes ASCII commands from a UART byte stream.
//   'R' -> o_run_stop, 'C' -> o_clear, 'S'<1..4 digits><CR|LF> -> o_load with
//   o_load_value; malformed or timed-out sequences -> o_err. All pulse outputs
//   are registered one cycle after the i_rx_done strobe.
//   clk, reset          : clock / async active-high reset
//   i_rx_data, i_rx_done: received byte and its one-cycle strobe
//   o_run_stop, o_clear, o_load, o_err : one-cycle pulses
//   o_load_value        : last loaded value, 0..9999
//   Build macro: CMD_LOWERCASE_EN makes 'r','c','s' aliases of 'R','C','S'.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_done,
    output logic        o_run_stop,
    output logic        o_clear,
    output logic        o_load,
    output logic [13:0] o_load_value,
    output logic        o_err
);

    logic [1:0]  state_q, state_d;
    logic [13:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d, clr_q, clr_d, load_q, load_d, err_q, err_d;
    logic [13:0] val_q, val_d;
    logic [7:0]  cmd;
    logic        expire;

    cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (i_rx_done || (state_q == ST_IDLE)),
        .enable_i (state_q != ST_IDLE),
        .expire_o (expire)
    );

    // Command letters are only matched in IDLE; folding case here keeps the
    // digit path untouched, so lowercase still errors inside a sequence.
`ifdef CMD_LOWERCASE_EN
    always_comb begin
        cmd = i_rx_data;
        if (i_rx_data == ASCII_LR || i_rx_data == ASCII_LC || i_rx_data == ASCII_LS)
            cmd = i_rx_data & 8'hDF;
    end
`else
    assign cmd = i_rx_data;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        run_d   = 1'b0;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        err_d   = 1'b0;
        // A byte in the expiry cycle takes precedence over the timeout.
        if (i_rx_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd == ASCII_R)      run_d = 1'b1;
                    else if (cmd == ASCII_C) clr_d = 1'b1;
                    else if (cmd == ASCII_S) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_DIGITS;
                    end
                end
                ST_DIGITS: begin
                    if (is_digit(i_rx_data)) begin
                        // Low nibble of '0'..'9' is the digit value.
                        acc_d = acc_q * 14'd10 + {10'd0, i_rx_data[3:0]};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd3) state_d = ST_WAITCR;
                    end else if (is_eol(i_rx_data) && cnt_q != 3'd0) begin
                        load_d  = 1'b1;
                        val_d   = acc_q;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_WAITCR: begin
                    if (is_eol(i_rx_data)) begin
                        load_d = 1'b1;
                        val_d  = acc_q;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (expire) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign o_run_stop   = run_q;
    assign o_clear      = clr_q;
    assign o_load       = load_q;
    assign o_err        = err_q;
    assign o_load_value = val_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder -- directed bench for uart_cmd_decoder with an expected-output
// queue: every driven cycle pushes the outputs expected one cycle later, and the
// next cycle pops and compares them.
module tb_uart_cmd_decoder;

    localparam int TO = 1000;

    typedef struct packed {
        logic        run;
        logic        clr;
        logic        ld;
        logic        err;
        logic [13:0] val;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        run_stop, clr, ld, err;
    logic [13:0] ld_val;

    int   checks = 0;
    int   failures = 0;
    out_t exp_q[$];
    string tag_q[$];
    logic [13:0] model_val = 14'd0;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_run_stop   (run_stop),
        .o_clear      (clr),
        .o_load       (ld),
        .o_load_value (ld_val),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    function automatic out_t observed();
        out_t o;
        o = '{run: run_stop, clr: clr, ld: ld, err: err, val: ld_val};
        return o;
    endfunction

    function automatic out_t mk(input logic r, input logic c, input logic l, input logic e);
        out_t o;
        o = '{run: r, clr: c, ld: l, err: e, val: model_val};
        return o;
    endfunction

    task automatic check(input string tag, input out_t exp);
        out_t obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed run=%b clr=%b ld=%b err=%b val=%0d expected run=%b clr=%b ld=%b err=%b val=%0d",
                   tag, obs.run, obs.clr, obs.ld, obs.err, obs.val,
                   exp.run, exp.clr, exp.ld, exp.err, exp.val);
        end
    endtask

    // One clock cycle: compare last cycle's expectation, then drive this cycle.
    task automatic tick(input logic dn, input logic [7:0] d, input string tag, input out_t e);
        @(negedge clk);
        if (exp_q.size() > 0) check(tag_q.pop_front(), exp_q.pop_front());
        rx_done = dn;
        rx_data = d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic byte_none(input logic [7:0] d, input string tag);
        tick(1'b1, d, tag, mk(0, 0, 0, 0));
    endtask

    task automatic byte_load(input logic [7:0] d, input logic [13:0] v, input string tag);
        model_val = v;
        tick(1'b1, d, tag, mk(0, 0, 1, 0));
    endtask

    // Idle cycles drive a command letter with no strobe: it must be ignored.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h52, tag, mk(0, 0, 0, 0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", mk(0, 0, 0, 0));
        reset = 1'b0;

        // Single run/stop pulse, one cycle only
        tick(1'b1, 8'h52, "run_R", mk(1, 0, 0, 0));
        idle(2, "run_R_after");
        tick(1'b1, 8'h43, "clear_C", mk(0, 1, 0, 0));

        // Four-digit load
        byte_none(8'h53, "s1234_S");
        byte_none(8'h31, "s1234_1");
        byte_none(8'h32, "s1234_2");
        byte_none(8'h33, "s1234_3");
        byte_none(8'h34, "s1234_4");
        byte_load(8'h0D, 14'd1234, "s1234_CR");
        idle(1, "s1234_after");

        // One digit with LF, then empty sequence errors and keeps value
        byte_none(8'h53, "s7_S");
        byte_none(8'h37, "s7_7");
        byte_load(8'h0A, 14'd7, "s7_LF");
        byte_none(8'h53, "sCR_S");
        tick(1'b1, 8'h0D, "sCR_err", mk(0, 0, 0, 1));

        // Back-to-back strobes: R, C, S 5 0 CR
        tick(1'b1, 8'h52, "b2b_R", mk(1, 0, 0, 0));
        tick(1'b1, 8'h43, "b2b_C", mk(0, 1, 0, 0));
        byte_none(8'h53, "b2b_S");
        byte_none(8'h35, "b2b_5");
        byte_none(8'h30, "b2b_0");
        byte_load(8'h0D, 14'd50, "b2b_CR");

        // Junk in IDLE is ignored
        byte_none(8'h0D, "idle_CR");
        byte_none(8'h0A, "idle_LF");
        byte_none(8'h78, "idle_x");
        byte_none(8'h39, "idle_9");

        // Fifth digit in WAIT_CR -> error
        byte_none(8'h53, "s5d_S");
        for (int i = 0; i < 4; i++) byte_none(8'h39, "s5d_9");
        tick(1'b1, 8'h35, "s5d_err", mk(0, 0, 0, 1));

        // Non-digit and lowercase inside DIGITS -> error
        byte_none(8'h53, "sA_S");
        byte_none(8'h32, "sA_2");
        tick(1'b1, 8'h41, "sA_err", mk(0, 0, 0, 1));
        byte_none(8'h53, "sr_S");
        tick(1'b1, 8'h72, "sr_err", mk(0, 0, 0, 1));

        // Max value 9999
        byte_none(8'h53, "s9999_S");
        for (int i = 0; i < 4; i++) byte_none(8'h39, "s9999_9");
        byte_load(8'h0A, 14'd9999, "s9999_LF");

        // Timeout: error exactly TO cycles after the last byte, once
        byte_none(8'h53, "to_S");
        byte_none(8'h31, "to_1");
        byte_none(8'h32, "to_2");
        idle(TO - 1, "to_wait");
        tick(1'b0, 8'h00, "to_err", mk(0, 0, 0, 1));
        idle(5, "to_after");
        tick(1'b1, 8'h43, "to_then_C", mk(0, 1, 0, 0));

        // A byte landing in the expiry cycle wins over the timeout
        byte_none(8'h53, "race_S");
        byte_none(8'h31, "race_1");
        idle(TO - 1, "race_wait");
        byte_load(8'h0D, 14'd1, "race_CR");
        idle(3, "race_after");

        // Reset mid-sequence discards partial digits silently
        byte_none(8'h53, "rst_S");
        byte_none(8'h34, "rst_4");
        idle(1, "rst_pre");
        @(negedge clk);
        check(tag_q.pop_front(), exp_q.pop_front());
        reset = 1'b1;
        #1;
        model_val = 14'd0;
        check("rst_async", mk(0, 0, 0, 0));
        @(negedge clk);
        check("rst_held", mk(0, 0, 0, 0));
        reset = 1'b0;
        byte_none(8'h0D, "rst_CR");
        tick(1'b1, 8'h52, "rst_then_R", mk(1, 0, 0, 0));

        // Lowercase command in IDLE
`ifdef CMD_LOWERCASE_EN
        tick(1'b1, 8'h72, "lower_r", mk(1, 0, 0, 0));
        tick(1'b1, 8'h63, "lower_c", mk(0, 1, 0, 0));
`else
        tick(1'b1, 8'h72, "lower_r", mk(0, 0, 0, 0));
        tick(1'b1, 8'h63, "lower_c", mk(0, 0, 0, 0));
`endif
        idle(2, "tail");
        @(negedge clk);
        check(tag_q.pop_front(), exp_q.pop_front());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
